// File: rtl/me_pkg.sv
// ---------------------------------------------------------------------------
// me_pkg
// Shared definitions for the motion-estimation MAD accumulator.
//   - Datapath widths and the saturation / reset-neutral constants
//   - State encoding for the accumulate pass controller
//   - Packed layout of one 21-bit MAD result word {sad, y, x}
// ---------------------------------------------------------------------------
package me_pkg;

    localparam int LANES = 8;
    localparam int PIX_W = 8;
    localparam int SAD_W = 13;
    localparam int MAD_W = 21;
    localparam int CNT_W = 9;

    localparam logic [SAD_W-1:0] SAD_MAX  = 13'd8191;
    localparam logic [MAD_W-1:0] MAD_INIT = 21'h1FFFFF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        EMIT  = 2'd2
    } state_t;

    typedef struct packed {
        logic [SAD_W-1:0] sad;
        logic [3:0]       y;
        logic [3:0]       x;
    } mad_t;

    // Builds one result word; the lane x index wraps naturally in 4 bits.
    function automatic mad_t pack_mad(input logic [SAD_W-1:0] sad,
                                      input logic [3:0]       y,
                                      input logic [3:0]       x);
        mad_t m;
        m.sad = sad;
        m.y   = y;
        m.x   = x;
        return m;
    endfunction

endpackage

// File: rtl/sad_lane.sv
// ---------------------------------------------------------------------------
// sad_lane
// One lane of the SAD engine: absolute difference of two 8-bit pixels added
// into a 13-bit accumulator that saturates at SAD_MAX instead of wrapping.
// Ports:
//   clk     - clock, rising edge
//   reset   - synchronous active-high reset, clears the accumulator
//   clear   - synchronous clear at the start of a pass
//   enable  - accumulate |cur_pix - ref_pix| this cycle
//   cur_pix - current-block pixel
//   ref_pix - reference pixel for this lane
//   acc     - running saturated sum
// ---------------------------------------------------------------------------
module sad_lane
    import me_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    input  logic [PIX_W-1:0] cur_pix,
    input  logic [PIX_W-1:0] ref_pix,
    output logic [SAD_W-1:0] acc
);

    logic [PIX_W-1:0] abs_diff;
    logic [SAD_W:0]   sum;

    // One extra bit on the sum exposes overflow past 13 bits for saturation.
    always_comb begin
        abs_diff = (cur_pix >= ref_pix) ? (cur_pix - ref_pix) : (ref_pix - cur_pix);
        sum      = {1'b0, acc} + {{(SAD_W + 1 - PIX_W){1'b0}}, abs_diff};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc <= '0;
        end else if (clear) begin
            acc <= '0;
        end else if (enable) begin
            acc <= sum[SAD_W] ? SAD_MAX : sum[SAD_W-1:0];
        end
    end

endmodule

// File: rtl/mad_accumulate.sv
// ---------------------------------------------------------------------------
// mad_accumulate
// Accumulates the sum of absolute differences between a stream of current
// block pixels and eight candidate reference positions in parallel, then
// publishes one {sad, y, x} word per candidate with a one-cycle strobe.
// Ports:
//   clk          - clock, rising edge
//   reset        - synchronous active-high reset, aborts any pass
//   start        - pulse in IDLE begins a pass, latches cand_x_base/cand_y
//   cand_x_base  - x index of lane 0 (lane k uses x_base + k mod 16)
//   cand_y       - y index shared by all lanes
//   pix_valid    - cur_pix/ref_pix valid this cycle (honoured in ACCUM only)
//   cur_pix      - current-block pixel
//   ref_pix      - eight reference pixels, lane i at [8i+7:8i]
//   mad_1..mad_8 - registered results, held between passes
//   compare_work - one-cycle pulse when mad_1..mad_8 are refreshed
//   busy         - high whenever a pass is in progress
// ---------------------------------------------------------------------------
module mad_accumulate
    import me_pkg::*;
#(
    parameter int BLOCK_PIXELS = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [3:0]             cand_x_base,
    input  logic [3:0]             cand_y,
    input  logic                   pix_valid,
    input  logic [PIX_W-1:0]       cur_pix,
    input  logic [LANES*PIX_W-1:0] ref_pix,
    output logic [MAD_W-1:0]       mad_1,
    output logic [MAD_W-1:0]       mad_2,
    output logic [MAD_W-1:0]       mad_3,
    output logic [MAD_W-1:0]       mad_4,
    output logic [MAD_W-1:0]       mad_5,
    output logic [MAD_W-1:0]       mad_6,
    output logic [MAD_W-1:0]       mad_7,
    output logic [MAD_W-1:0]       mad_8,
    output logic                   compare_work,
    output logic                   busy
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BLOCK_PIXELS - 1);

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] pix_count;
    logic [3:0]       x_base_q;
    logic [3:0]       y_q;
    logic             start_pass;
    logic             accept_pix;
    logic             last_pix;
    logic [SAD_W-1:0] acc [LANES];
    mad_t             mad_q [LANES];

    // A start only counts in IDLE; a pixel only counts in ACCUM. A pixel
    // presented together with the start pulse is therefore dropped.
    always_comb begin
        start_pass = (state == IDLE) && start;
        accept_pix = (state == ACCUM) && pix_valid;
        last_pix   = accept_pix && (pix_count == LAST_IDX);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // EMIT lasts exactly one cycle, so a start there falls on deaf ears.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = ACCUM;
            ACCUM:   if (last_pix) state_next = EMIT;
            EMIT:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Pixel counter and candidate position latched for the whole pass.
    always_ff @(posedge clk) begin
        if (reset) begin
            pix_count <= '0;
            x_base_q  <= '0;
            y_q       <= '0;
        end else if (start_pass) begin
            pix_count <= '0;
            x_base_q  <= cand_x_base;
            y_q       <= cand_y;
        end else if (accept_pix) begin
            pix_count <= pix_count + 1'b1;
        end
    end

    genvar g;
    generate
        for (g = 0; g < LANES; g++) begin : g_lane
            sad_lane u_lane (
                .clk     (clk),
                .reset   (reset),
                .clear   (start_pass),
                .enable  (accept_pix),
                .cur_pix (cur_pix),
                .ref_pix (ref_pix[g*PIX_W +: PIX_W]),
                .acc     (acc[g])
            );
        end
    endgenerate

    // Results are captured during EMIT, so they appear one edge after the
    // final pixel edge; reset loads the worst-case MAD so a downstream
    // minimum search never picks a stale or aborted result.
    always_ff @(posedge clk) begin
        if (reset) begin
            compare_work <= 1'b0;
            for (int i = 0; i < LANES; i++) begin
                mad_q[i] <= mad_t'(MAD_INIT);
            end
        end else begin
            compare_work <= (state == EMIT);
            if (state == EMIT) begin
                for (int i = 0; i < LANES; i++) begin
                    mad_q[i] <= pack_mad(acc[i], y_q, x_base_q + 4'(i));
                end
            end
        end
    end

    always_comb begin
        busy  = (state != IDLE);
        mad_1 = mad_q[0];
        mad_2 = mad_q[1];
        mad_3 = mad_q[2];
        mad_4 = mad_q[3];
        mad_5 = mad_q[4];
        mad_6 = mad_q[5];
        mad_7 = mad_q[6];
        mad_8 = mad_q[7];
    end

endmodule

// File: tb/tb_mad_accumulate.sv
// ---------------------------------------------------------------------------
// tb_mad_accumulate
// Randomized scoreboard bench: each pass's expected results are computed from
// plain arithmetic on the generated pixels and queued; a monitor pops and
// compares whenever compare_work is seen.
// ---------------------------------------------------------------------------
module tb_mad_accumulate;
    import me_pkg::*;

    localparam int BP = 64;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  cand_x_base;
    logic [3:0]  cand_y;
    logic        pix_valid;
    logic [7:0]  cur_pix;
    logic [63:0] ref_pix;
    logic [20:0] mad_out [8];
    logic        compare_work;
    logic        busy;

    typedef struct packed {
        logic [7:0][20:0] mad;
        logic [31:0]      due;
    } exp_t;

    exp_t             sb[$];
    exp_t             mon_e;
    logic [7:0][20:0] lastExp;
    logic [7:0]       curA [BP];
    logic [63:0]      refA [BP];
    int               cyc = 0;
    int               checks = 0;
    int               errors = 0;

    mad_accumulate #(.BLOCK_PIXELS(BP)) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .cand_x_base  (cand_x_base),
        .cand_y       (cand_y),
        .pix_valid    (pix_valid),
        .cur_pix      (cur_pix),
        .ref_pix      (ref_pix),
        .mad_1        (mad_out[0]),
        .mad_2        (mad_out[1]),
        .mad_3        (mad_out[2]),
        .mad_4        (mad_out[3]),
        .mad_5        (mad_out[4]),
        .mad_6        (mad_out[5]),
        .mad_7        (mad_out[6]),
        .mad_8        (mad_out[7]),
        .compare_work (compare_work),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    // Monitor: every compare_work strobe must match the oldest queued pass.
    always @(negedge clk) begin
        if (compare_work === 1'b1) begin
            if (sb.size() == 0) begin
                checkOutput("unexpected_pulse", {31'd0, compare_work}, 32'd0);
            end else begin
                mon_e = sb.pop_front();
                for (int k = 0; k < 8; k++) begin
                    checkOutput($sformatf("mad_%0d", k + 1), {11'd0, mad_out[k]},
                                {11'd0, mon_e.mad[k]});
                end
                checkOutput("pulse_cycle", cyc, mon_e.due);
                lastExp = mon_e.mad;
            end
        end
    end

    // mode: 0 random, 1 all equal 10, 2 cur 255 / ref 0, 3 lane i ref = cur + i
    // gapMode: 0 none, 1 every other cycle, 2 random gaps
    task automatic applyStimulus(input logic [3:0] xb, input logic [3:0] yy,
                                 input int mode, input int gapMode, input int abortAt,
                                 input bit extraStarts, input bit pixOnStart);
        int   sad [8];
        int   r;
        int   n;
        bit   busyOk;
        bit   gapToggle;
        logic [7:0] c;
        logic [7:0] rb;
        exp_t e;

        for (int i = 0; i < 8; i++) sad[i] = 0;
        for (int p = 0; p < BP; p++) begin
            case (mode)
                1:       c = 8'd10;
                2:       c = 8'd255;
                3:       c = 8'($urandom_range(0, 247));
                default: c = 8'($urandom);
            endcase
            curA[p] = c;
            for (int i = 0; i < 8; i++) begin
                case (mode)
                    1:       rb = 8'd10;
                    2:       rb = 8'd0;
                    3:       rb = c + 8'(i);
                    default: rb = 8'($urandom);
                endcase
                refA[p][8*i +: 8] = rb;
                r = int'(c) - int'(rb);
                sad[i] += (r < 0) ? -r : r;
            end
        end
        for (int k = 0; k < 8; k++) begin
            if (sad[k] > 8191) sad[k] = 8191;
            e.mad[k] = {13'(sad[k]), yy, 4'((int'(xb) + k) % 16)};
        end

        @(posedge clk); #1;
        start       = 1'b1;
        cand_x_base = xb;
        cand_y      = yy;
        pix_valid   = pixOnStart;
        cur_pix     = 8'($urandom);
        ref_pix     = {$urandom, $urandom};
        n           = 0;
        busyOk      = 1'b1;
        gapToggle   = 1'b0;

        while (n < BP) begin
            @(posedge clk); #1;
            if (busy !== 1'b1) busyOk = 1'b0;
            start       = extraStarts && (n == 20);
            cand_x_base = 4'($urandom);
            cand_y      = 4'($urandom);
            if (abortAt >= 0 && n == abortAt) begin
                reset     = 1'b1;
                start     = 1'b1;
                pix_valid = 1'b1;
                @(posedge clk); #1;
                reset     = 1'b0;
                start     = 1'b0;
                pix_valid = 1'b0;
                checkOutput("abort_busy", {31'd0, busy}, 32'd0);
                checkOutput("abort_cw", {31'd0, compare_work}, 32'd0);
                for (int k = 0; k < 8; k++) begin
                    checkOutput($sformatf("abort_mad_%0d", k + 1), {11'd0, mad_out[k]},
                                {11'd0, MAD_INIT});
                    lastExp[k] = MAD_INIT;
                end
                repeat (3) @(posedge clk);
                #1 checkOutput("abort_idle", {31'd0, busy}, 32'd0);
                return;
            end
            if (gapMode == 1) gapToggle = ~gapToggle;
            else if (gapMode == 2) gapToggle = ($urandom_range(0, 99) < 30);
            if (gapToggle) begin
                pix_valid = 1'b0;
                cur_pix   = 8'($urandom);
                ref_pix   = {$urandom, $urandom};
            end else begin
                pix_valid = 1'b1;
                cur_pix   = curA[n];
                ref_pix   = refA[n];
                if (n == BP - 1) begin
                    e.due = 32'(cyc + 2);
                    sb.push_back(e);
                end
                n++;
            end
        end

        // This slot is sampled during EMIT: start and pixel must be ignored.
        @(posedge clk); #1;
        if (busy !== 1'b1) busyOk = 1'b0;
        start     = extraStarts;
        pix_valid = 1'b1;
        cur_pix   = 8'($urandom);
        @(posedge clk); #1;
        start     = 1'b0;
        pix_valid = 1'b0;
        checkOutput("busy_after_emit", {31'd0, busy}, 32'd0);
        checkOutput("busy_during_pass", {31'd0, busyOk}, 32'd1);
    endtask

    task automatic checkHold();
        repeat (5) @(posedge clk);
        #1;
        for (int k = 0; k < 8; k++) begin
            checkOutput($sformatf("hold_%0d", k + 1), {11'd0, mad_out[k]}, {11'd0, lastExp[k]});
        end
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        reset       = 1'b1;
        start       = 1'b0;
        pix_valid   = 1'b0;
        cand_x_base = '0;
        cand_y      = '0;
        cur_pix     = '0;
        ref_pix     = '0;
        for (int k = 0; k < 8; k++) lastExp[k] = MAD_INIT;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        checkOutput("reset_busy", {31'd0, busy}, 32'd0);
        checkOutput("reset_cw", {31'd0, compare_work}, 32'd0);
        for (int k = 0; k < 8; k++) begin
            checkOutput($sformatf("reset_mad_%0d", k + 1), {11'd0, mad_out[k]}, {11'd0, MAD_INIT});
        end

        applyStimulus(4'd0, 4'd5, 1, 0, -1, 1'b0, 1'b0);
        checkHold();
        applyStimulus(4'd3, 4'd9, 2, 0, -1, 1'b0, 1'b1);
        applyStimulus(4'd7, 4'd2, 3, 1, -1, 1'b0, 1'b0);
        applyStimulus(4'd12, 4'd15, 0, 0, -1, 1'b0, 1'b0);
        checkHold();
        applyStimulus(4'd4, 4'd4, 0, 2, 30, 1'b0, 1'b0);
        applyStimulus(4'd4, 4'd4, 0, 2, -1, 1'b0, 1'b0);
        applyStimulus(4'd9, 4'd1, 0, 0, -1, 1'b1, 1'b0);
        for (int t = 0; t < 4; t++) begin
            applyStimulus(4'($urandom), 4'($urandom), int'($urandom_range(0, 3)),
                          int'($urandom_range(0, 2)), -1, 1'($urandom), 1'($urandom));
        end
        checkHold();

        for (int w = 0; w < 20 && sb.size() != 0; w++) @(posedge clk);
        checkOutput("drain", sb.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mad_accumulate.md
MAD_ACCUMULATE -- requirements
Module: mad_accumulate

Interface
REQ-001 The block SHALL have parameter BLOCK_PIXELS, default 64, giving the pixels accumulated per pass (legal range 1..256).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port start, input, 1 bit: one-cycle pulse that begins a pass.
REQ-005 The block SHALL have port cand_x_base, input, 4 bits: x index of lane 0; it is sampled on start.
REQ-006 The block SHALL have port cand_y, input, 4 bits: y index shared by all lanes; it is sampled on start.
REQ-007 The block SHALL have port pix_valid, input, 1 bit: cur_pix and ref_pix are valid this cycle.
REQ-008 The block SHALL have port cur_pix, input, 8 bits: current-block pixel.
REQ-009 The block SHALL have port ref_pix, input, 64 bits: the reference pixel for lane i is at bits [8i+7:8i], for i = 0..7.
REQ-010 The block SHALL have ports mad_1..mad_8, output, 21 bits each: {sad[12:0], y[3:0], x[3:0]}, where mad_k is lane k-1.
REQ-011 The block SHALL have port compare_work, output, 1 bit: a one-cycle pulse marking mad_1..mad_8 as newly valid.
REQ-012 The block SHALL have port busy, output, 1 bit: high while the state is not IDLE.

Function
REQ-013 The state machine SHALL have the states IDLE, ACCUM and EMIT, with these transitions:
- IDLE to ACCUM on start.
- ACCUM to EMIT when the BLOCK_PIXELS-th pix_valid is accepted.
- EMIT to IDLE unconditionally after one cycle.
REQ-014 On start in IDLE, the block SHALL clear all eight accumulators and the pixel counter, and latch cand_x_base and cand_y.
REQ-015 start SHALL be ignored in ACCUM and EMIT; pix_valid SHALL be ignored in IDLE and EMIT.
REQ-016 start and pix_valid in the same IDLE cycle SHALL start the pass only; that pixel SHALL NOT be accumulated.
REQ-017 In ACCUM, each pix_valid cycle SHALL add |cur_pix - ref_pix lane i| (unsigned, 8 bits) to accumulator i.
REQ-018 Each accumulator SHALL be 13 bits and SHALL saturate at 8191; it SHALL never wrap.
REQ-019 In ACCUM, the pixel counter SHALL increment only on pix_valid; gaps in pix_valid SHALL stall the pass without loss.
REQ-020 In the EMIT cycle, the block SHALL register mad_k = {acc[k-1], y_latched, (x_base_latched + k-1) mod 16} and assert compare_work for exactly one cycle.
REQ-021 The lane x index SHALL wrap modulo 16 (for example, base 12: lane 4 gets x = 0).
REQ-022 Latency: if the final pix_valid is sampled at edge T, mad_* and compare_work SHALL be visible after edge T+1.
REQ-023 mad_1..mad_8 SHALL hold their value between EMIT cycles.
REQ-024 A start pulse in the EMIT cycle SHALL be ignored; the earliest accepted next start is the cycle after EMIT.

Reset
REQ-025 When reset is high at a clock edge, the block SHALL set state = IDLE, busy = 0, compare_work = 0, all accumulators and the counter to 0, and mad_1..mad_8 = 21'h1FFFFF (worst-case MAD, neutral for the downstream minimum search).
REQ-026 Reset during ACCUM or EMIT SHALL abort the pass; no compare_work pulse SHALL follow.
REQ-027 Reset SHALL take priority over start and pix_valid in the same cycle.

Structure
REQ-028 Shared package me_pkg SHALL hold:
- constants LANES = 8, PIX_W = 8, SAD_W = 13, MAD_W = 21, SAD_MAX = 8191, MAD_INIT = 21'h1FFFFF;
- the state enum for IDLE, ACCUM and EMIT;
- the 21-bit MAD field layout.
REQ-029 Sub-module sad_lane SHALL contain the absolute difference plus the saturating 13-bit accumulator, with clear and enable inputs.
REQ-030 mad_accumulate SHALL instantiate sad_lane eight times and keep the FSM, counter and output registers at top level.

Verification
REQ-031 Scenario: cur = 10, every lane ref = 10, BLOCK_PIXELS = 64, base x = 0, y = 5.
Response: compare_work fires once, one cycle after the 64th valid; mad_k = {13'd0, 4'd5, 4'(k-1)}.
REQ-032 Scenario: cur = 255, every lane ref = 0, 64 pixels.
Response: all sad fields = 8191 (saturated, not 16320 mod 8192).
REQ-033 Scenario: lane i ref = cur + i every pixel, 64 pixels, pix_valid low every other cycle.
Response: sad lane i = 64*i; the pass takes 128 active cycles; busy is high throughout.
REQ-034 Scenario: cand_x_base = 12, y = 15.
Response: x fields are 12, 13, 14, 15, 0, 1, 2, 3; the y field is 15 in all lanes.
REQ-035 Scenario: reset asserted after 30 valid pixels.
Response: no compare_work pulse, all mad = 21'h1FFFFF, busy = 0; a fresh start then yields correct sums with no residue from the aborted pass.
REQ-036 Scenario: start pulsed mid-ACCUM and again in the EMIT cycle.
Response: both pulses are ignored; sums are unaffected; state returns to IDLE after EMIT.
